accum_rr_scheduler: RTL and testbench
=====================================

Name: accum_rr_scheduler

Overview:
Round-robin scheduler that shares one WIDTH-bit accumulator register between NREQ requesters. Each accepted request is one of four ops: increment, load, clear or add. The block sequences each op through a fixed accept/execute/hold cycle and reports completion per requester. It sits in front of the counter/register-update datapaths and serialises all updates to the shared state.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, accumulator width in bits
INIT, 0, accumulator value after reset and after CLEAR
HOLD, 2, idle cycles inserted after each execute (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
io_req_valid  input  NREQ  per-requester request valid
io_req_ready  output  NREQ  one-hot grant/accept, bit i means requester i accepted this cycle
io_req_op  input  2*NREQ  op for requester i in bits [2i+1:2i]; 0=INC, 1=LOAD, 2=CLEAR, 3=ADD
io_req_data  input  WIDTH*NREQ  operand for requester i in bits [WIDTH*(i+1)-1:WIDTH*i]
io_out  output  WIDTH  current accumulator value, driven directly from the register
io_busy  output  1  high in EXEC and HOLD
io_done  output  1  one-cycle pulse in the cycle after the accumulator updates
io_done_id  output  log2(NREQ)  index of the completed requester, valid when io_done=1

Behaviour:
- Reset (reset=0 at a clk edge):
  - accumulator=INIT, state=IDLE, rr pointer=0, hold counter=0.
  - io_req_ready=0, io_busy=0, io_done=0, io_done_id=0.
  - Reset overrides any in-flight op: the captured request is dropped and io_done is never produced for it.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - io_req_ready is one-hot on the winner when any io_req_valid bit is set; otherwise it is 0.
  - Winner is the first valid index at or after the rr pointer, searching upward with wrap NREQ-1 to 0.
  - io_req_ready is combinational from io_req_valid and the pointer. Requesters must not depend on ready to drive valid.
  - A handshake (valid & ready) in IDLE captures op, data and id.
  - Same edge: pointer becomes winner+1 mod NREQ, and the state goes to EXEC.
- EXEC (exactly one cycle):
  - io_req_ready=0.
  - At the end of the cycle the accumulator is written:
    - INC: acc+1
    - LOAD: data
    - CLEAR: INIT
    - ADD: acc+data
  - All arithmetic is modulo 2^WIDTH; carry-out is discarded, so all-ones + 1 gives 0.
  - Next state is HOLD if HOLD>0, else IDLE.
- io_done timing: io_done=1 with io_done_id=captured id in the cycle after EXEC, whether that cycle is HOLD or IDLE.
- HOLD:
  - Counter loads HOLD on entry and decrements each cycle; the state returns to IDLE when it reaches 1.
  - io_req_ready=0 throughout.
- Throughput:
  - One op per 2+HOLD cycles.
  - Latency from handshake edge to new io_out is 1 cycle.
  - io_out is the register value, so it changes only at the EXEC edge.
- Requests not granted are neither consumed nor lost. Requesters hold valid, op and data stable until ready.
- Deasserting valid before a grant is legal and withdraws the request.
- The pointer only advances on a handshake. With a single requester continuously valid, that requester wins every IDLE cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all valids=1 -> io_out=0, io_req_ready=0000, io_busy=0, io_done=0; after release, first grant goes to requester 0.
- Single INC, HOLD=2: req0 INC at cycle t -> ready[0]=1 at t, io_out=1 from t+2, io_busy=1 at t+1..t+3, io_done=1 with id 0 at t+2, next ready at t+4.
- Round-robin fairness: all four valid with ops LOAD 5, ADD 3, INC, ADD 10 -> grant order 0,1,2,3,0; io_out sequence 5, 8, 9, 19.
- Wrap-around: LOAD 0xFFFFFFFF then INC -> io_out=0x00000000; then ADD 0xFFFFFFFF -> 0xFFFFFFFF; then ADD 2 -> 0x00000001.
- Mid-op reset: assert reset=0 during EXEC of ADD 7 with acc=4 -> acc=0 (INIT), no io_done pulse, pointer=0.
- HOLD=0 back-to-back: req2 continuously valid with INC -> grant every 2nd cycle; io_out 1, 2, 3 at 2-cycle spacing; io_done_id=2 each time.

Source files
------------

// File: rtl/accum_rr_scheduler.sv
// accum_rr_scheduler
//   Round-robin arbiter in front of one shared accumulator register. Each
//   granted request runs one op (INC / LOAD / CLEAR / ADD) through a fixed
//   accept -> execute -> hold sequence, then completion is reported with the
//   requester index.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | arbitrating; grant is combinational, handshake captures request
//   EXEC  | one cycle; accumulator is written at the end of this cycle
//   HOLD  | HOLD idle cycles after execute; no grants
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous, active-low reset
//   io_req_valid : per-requester request valid            [NREQ]
//   io_req_ready : one-hot grant, only in IDLE             [NREQ]
//   io_req_op    : per-requester op, 2 bits each           [2*NREQ]
//   io_req_data  : per-requester operand, WIDTH bits each  [WIDTH*NREQ]
//   io_out       : accumulator register value              [WIDTH]
//   io_busy      : high in EXEC and HOLD
//   io_done      : one-cycle pulse in the cycle after the accumulator update
//   io_done_id   : requester index of the completed op     [log2(NREQ)]
module accum_rr_scheduler #(
    parameter int               NREQ  = 4,
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          io_req_valid,
    output logic [NREQ-1:0]          io_req_ready,
    input  logic [2*NREQ-1:0]        io_req_op,
    input  logic [WIDTH*NREQ-1:0]    io_req_data,
    output logic [WIDTH-1:0]         io_out,
    output logic                     io_busy,
    output logic                     io_done,
    output logic [$clog2(NREQ)-1:0]  io_done_id
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] OP_INC   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_ADD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [PW-1:0]     id_q, id_d;
    logic              done_q, done_d;
    logic [PW-1:0]     done_id_q, done_id_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    logic [NREQ-1:0]   grant;
    logic              handshake;

    // First valid requester at or after the pointer, wrapping NREQ-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && io_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant is gated by reset so nothing is offered while reset is asserted.
    always_comb begin
        grant = '0;
        if (reset && (state_q == ST_IDLE) && win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign handshake = |(grant & io_req_valid);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        op_d      = op_q;
        data_d    = data_q;
        id_d      = id_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    op_d    = io_req_op[2*win_idx +: 2];
                    data_d  = io_req_data[WIDTH*win_idx +: WIDTH];
                    id_d    = win_idx;
                    ptr_d   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_INC:   acc_d = acc_q + WIDTH'(1);
                    OP_LOAD:  acc_d = data_q;
                    OP_CLEAR: acc_d = INIT;
                    OP_ADD:   acc_d = acc_q + data_q;
                    default:  acc_d = acc_q;
                endcase
                done_d    = 1'b1;
                done_id_d = id_q;
                if (HOLD > 0) begin
                    state_d = ST_HOLD;
                    cnt_d   = 4'(HOLD);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Counter was loaded with HOLD on entry; leave on the cycle it reads 1.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= INIT;
            op_q      <= OP_INC;
            data_q    <= '0;
            id_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            data_q    <= data_d;
            id_q      <= id_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign io_req_ready = grant;
    assign io_out       = acc_q;
    assign io_busy      = (state_q != ST_IDLE);
    assign io_done      = done_q;
    assign io_done_id   = done_id_q;

endmodule

// File: tb/tb_accum_rr_scheduler.sv
module tb_accum_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int HOLDM = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, HOLD=2
    logic          rst0;
    logic [3:0]    valid0;
    logic [3:0]    ready0;
    logic [7:0]    op0;
    logic [127:0]  data0;
    logic [31:0]   out0;
    logic          busy0;
    logic          done0;
    logic [1:0]    id0;

    // second instance, HOLD=0
    logic          rst1;
    logic [3:0]    valid1;
    logic [3:0]    ready1;
    logic [7:0]    op1;
    logic [127:0]  data1;
    logic [31:0]   out1;
    logic          busy1;
    logic          done1;
    logic [1:0]    id1;

    accum_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .INIT('0), .HOLD(HOLDM)) u_dut (
        .clk(clk), .reset(rst0), .io_req_valid(valid0), .io_req_ready(ready0),
        .io_req_op(op0), .io_req_data(data0), .io_out(out0), .io_busy(busy0),
        .io_done(done0), .io_done_id(id0)
    );

    accum_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .INIT('0), .HOLD(0)) u_dut_h0 (
        .clk(clk), .reset(rst1), .io_req_valid(valid1), .io_req_ready(ready1),
        .io_req_op(op1), .io_req_data(data1), .io_out(out1), .io_busy(busy1),
        .io_done(done1), .io_done_id(id1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]   valid;
        logic [7:0]   op;
        logic [127:0] data;
        logic [3:0]   exp_ready;
        logic [31:0]  exp_out;
        logic [1:0]   exp_id;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [7:0] o,
                                input logic [31:0] d3, input logic [31:0] d2,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic [3:0] r, input logic [31:0] eo,
                                input logic [1:0] ei);
        vec_t x;
        x.valid = v; x.op = o; x.data = {d3, d2, d1, d0};
        x.exp_ready = r; x.exp_out = eo; x.exp_id = ei;
        return x;
    endfunction

    // Starts at a negedge of an idle cycle, ends at a negedge of the next idle cycle.
    task automatic run_rec(input vec_t v);
        int n;
        valid0 = v.valid; op0 = v.op; data0 = v.data;
        #1;
        chk("grant", 32'(ready0), 32'(v.exp_ready));
        chk("busy_idle", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        valid0 = '0;
        @(negedge clk);
        chk("busy_exec", 32'(busy0), 32'd1);
        chk("ready_exec", 32'(ready0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("acc", out0, v.exp_out);
        chk("done", 32'(done0), 32'd1);
        chk("done_id", 32'(id0), 32'(v.exp_id));
        n = 0;
        while (busy0 && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("hold_len", 32'(n), 32'(HOLDM));
    endtask

    task automatic do_reset();
        rst0 = 1'b0; valid0 = '0;
        @(posedge clk);
        @(negedge clk);
        rst0 = 1'b1;
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // transaction-level reference model
    logic [31:0] m_acc;
    int          m_ptr, m_wait, m_id;
    logic        m_exec, m_done;
    logic [1:0]  m_done_id, m_op;
    logic [31:0] m_data;

    task automatic model_reset();
        m_acc = '0; m_ptr = 0; m_wait = 0; m_exec = 1'b0;
        m_done = 1'b0; m_done_id = '0; m_id = 0; m_op = '0; m_data = '0;
    endtask

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b0; valid0 = 4'b1111; op0 = '0; data0 = '0;
        rst1 = 1'b0; valid1 = '0; op1 = '0; data1 = '0;

        // reset held with all requesters valid
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out", out0, 32'd0);
            chk("rst_ready", 32'(ready0), 32'd0);
            chk("rst_busy", 32'(busy0), 32'd0);
            chk("rst_done", 32'(done0), 32'd0);
        end
        rst0 = 1'b1;
        #1;
        chk("first_grant", 32'(ready0), 32'b0001);

        // single INC from requester 0
        run_rec(mk(4'b0001, 8'h00, 0, 0, 0, 0, 4'b0001, 32'd1, 2'd0));

        do_reset();

        tbl[0]  = mk(4'b1111, {2'd3,2'd0,2'd3,2'd1}, 32'd10, 32'd0, 32'd3, 32'd5, 4'b0001, 32'd5,  2'd0);
        tbl[1]  = mk(4'b1111, {2'd3,2'd0,2'd3,2'd1}, 32'd10, 32'd0, 32'd3, 32'd5, 4'b0010, 32'd8,  2'd1);
        tbl[2]  = mk(4'b1111, {2'd3,2'd0,2'd3,2'd1}, 32'd10, 32'd0, 32'd3, 32'd5, 4'b0100, 32'd9,  2'd2);
        tbl[3]  = mk(4'b1111, {2'd3,2'd0,2'd3,2'd1}, 32'd10, 32'd0, 32'd3, 32'd5, 4'b1000, 32'd19, 2'd3);
        tbl[4]  = mk(4'b1111, {2'd3,2'd0,2'd3,2'd1}, 32'd10, 32'd0, 32'd3, 32'd5, 4'b0001, 32'd5,  2'd0);
        tbl[5]  = mk(4'b0010, {2'd0,2'd0,2'd1,2'd0}, 0, 0, 32'hFFFF_FFFF, 0, 4'b0010, 32'hFFFF_FFFF, 2'd1);
        tbl[6]  = mk(4'b0010, {2'd0,2'd0,2'd0,2'd0}, 0, 0, 0, 0, 4'b0010, 32'h0000_0000, 2'd1);
        tbl[7]  = mk(4'b0010, {2'd0,2'd0,2'd3,2'd0}, 0, 0, 32'hFFFF_FFFF, 0, 4'b0010, 32'hFFFF_FFFF, 2'd1);
        tbl[8]  = mk(4'b0010, {2'd0,2'd0,2'd3,2'd0}, 0, 0, 32'd2, 0, 4'b0010, 32'h0000_0001, 2'd1);
        tbl[9]  = mk(4'b1000, {2'd2,2'd0,2'd0,2'd0}, 32'd99, 0, 0, 0, 4'b1000, 32'd0, 2'd3);
        tbl[10] = mk(4'b0110, {2'd0,2'd3,2'd0,2'd0}, 0, 32'd7, 0, 0, 4'b0010, 32'd1, 2'd1);
        tbl[11] = mk(4'b0110, {2'd0,2'd3,2'd0,2'd0}, 0, 32'd7, 0, 0, 4'b0100, 32'd8, 2'd2);
        tbl[12] = mk(4'b0001, {2'd0,2'd0,2'd0,2'd3}, 0, 0, 0, 32'h10, 4'b0001, 32'h18, 2'd0);
        for (int i = 0; i < 13; i++) run_rec(tbl[i]);

        // reset in the middle of EXEC: ADD 7 with acc=4 is dropped
        run_rec(mk(4'b0001, 8'h01, 0, 0, 0, 32'd4, 4'b0001, 32'd4, 2'd0));
        valid0 = 4'b0010; op0 = {2'd0,2'd0,2'd3,2'd0}; data0 = {32'd0, 32'd0, 32'd7, 32'd0};
        #1;
        chk("midrst_grant", 32'(ready0), 32'b0010);
        @(posedge clk); #1;
        valid0 = '0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy0), 32'd1);
        rst0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_acc", out0, 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        chk("midrst_busy2", 32'(busy0), 32'd0);
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_nodone", 32'(done0), 32'd0);
        chk("midrst_acc2", out0, 32'd0);
        valid0 = 4'b1111;
        #1;
        chk("midrst_ptr", 32'(ready0), 32'b0001);
        valid0 = '0;

        // HOLD=0, requester 2 continuously valid with INC
        rst1 = 1'b1; valid1 = 4'b0100; op1 = '0; data1 = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk("h0_ready", 32'(ready1), 32'b0100);
                chk("h0_busy", 32'(busy1), 32'd0);
                chk("h0_out", out1, 32'(i / 2));
                chk("h0_done", 32'(done1), (i > 0) ? 32'd1 : 32'd0);
                if (i > 0) chk("h0_id", 32'(id1), 32'd2);
            end else begin
                chk("h0_ready", 32'(ready1), 32'd0);
                chk("h0_busy", 32'(busy1), 32'd1);
                chk("h0_out", out1, 32'((i - 1) / 2));
                chk("h0_done", 32'(done1), 32'd0);
            end
            @(negedge clk);
        end
        valid1 = '0;

        // randomized traffic against the reference model
        @(negedge clk);
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] er;
            int w;
            @(posedge clk); #1;
            rst0 = ($urandom_range(0, 63) != 0);
            valid0 = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            op0 = 8'($urandom);
            for (int r = 0; r < NREQ; r++)
                data0[32*r +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            @(negedge clk);
            w = rr_pick(valid0, m_ptr);
            er = '0;
            if (rst0 && m_wait == 0 && w >= 0) er = 4'b0001 << w;
            chk("rnd_ready", 32'(ready0), 32'(er));
            chk("rnd_out", out0, m_acc);
            chk("rnd_busy", 32'(busy0), (m_wait != 0) ? 32'd1 : 32'd0);
            chk("rnd_done", 32'(done0), 32'(m_done));
            if (m_done) chk("rnd_id", 32'(id0), 32'(m_done_id));
            if (!rst0) begin
                model_reset();
            end else begin
                m_done = m_exec;
                if (m_exec) begin
                    m_done_id = 2'(m_id);
                    case (m_op)
                        2'd0: m_acc = m_acc + 32'd1;
                        2'd1: m_acc = m_data;
                        2'd2: m_acc = 32'd0;
                        default: m_acc = m_acc + m_data;
                    endcase
                end
                m_exec = 1'b0;
                if (m_wait > 0) m_wait--;
                if (er != 0) begin
                    m_exec = 1'b1;
                    m_id   = w;
                    m_op   = op0[2*w +: 2];
                    m_data = data0[32*w +: 32];
                    m_wait = 1 + HOLDM;
                    m_ptr  = (w + 1) % NREQ;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
